pipe_stage_buf: RTL and testbench

//   Parametrised pipeline stage register for the five-stage MIPS core. Successor to the

---
 rtl/pipe_stage_buf_if.sv | 15 +
 rtl/pipe_stage_buf.sv | 108 ++++++++++
 tb/tb_pipe_stage_buf.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: upstream and downstream valid/ready bundle around one pipeline stage
interface pipe_stage_buf_if #(parameter int DATA_W = 128);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_data;
    modport master (output in_valid, in_pc, in_data, out_ready,
                    input  in_ready, out_valid, out_pc, out_data);
    modport slave  (input  in_valid, in_pc, in_data, out_ready,
                    output in_ready, out_valid, out_pc, out_data);
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: PC + payload pipeline register with stall, flush, optional skid buffer and bubble counter
module pipe_stage_buf #(
    parameter int          DATA_W   = 128,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter bit          SKID     = 1'b1,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_buf_if.slave  bus,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic              r_valid;
    logic [31:0]       r_pc;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    assign bus.out_valid = r_valid;
    assign bus.out_pc    = r_pc;
    assign bus.out_data  = r_data;
    assign bubble_cnt    = r_cnt;

    generate
        if (SKID) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
            state_t            r_state;
            logic              r_in_ready;
            logic [31:0]       r_s_pc;
            logic [DATA_W-1:0] r_s_data;
            // in_ready is a flop so no combinational path reaches upstream from out_ready
            assign bus.in_ready = r_in_ready;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state    <= EMPTY;
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_pc       <= PC_RESET;
                    r_data     <= '0;
                    r_s_pc     <= '0;
                    r_s_data   <= '0;
                end else if (flush) begin
                    r_state    <= EMPTY;
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_data     <= '0;
                end else begin
                    case (r_state)
                        EMPTY: if (bus.in_valid) begin
                            r_state <= ONE;
                            r_valid <= 1'b1;
                            r_pc    <= bus.in_pc;
                            r_data  <= bus.in_data;
                        end
                        ONE: if (bus.in_valid && bus.out_ready) begin
                            r_pc   <= bus.in_pc;
                            r_data <= bus.in_data;
                        end else if (bus.in_valid) begin
                            r_state    <= FULL;
                            r_in_ready <= 1'b0;
                            r_s_pc     <= bus.in_pc;
                            r_s_data   <= bus.in_data;
                        end else if (bus.out_ready) begin
                            r_state <= EMPTY;
                            r_valid <= 1'b0;
                        end
                        FULL: if (bus.out_ready) begin
                            r_state    <= ONE;
                            r_in_ready <= 1'b1;
                            r_pc       <= r_s_pc;
                            r_data     <= r_s_data;
                        end
                        default: r_state <= EMPTY;
                    endcase
                end
            end
        end else begin : g_single
            logic w_in_ready;
            logic w_in_xfer;
            assign w_in_ready   = !r_valid || bus.out_ready;
            assign w_in_xfer    = bus.in_valid && w_in_ready;
            assign bus.in_ready = w_in_ready;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_pc    <= PC_RESET;
                    r_data  <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_in_xfer) begin
                    r_valid <= 1'b1;
                    r_pc    <= bus.in_pc;
                    r_data  <= bus.in_data;
                end else if (bus.out_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (!r_valid && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed scoreboard bench for the skid, single-register and narrow-counter variants
module tb_pipe_stage_buf;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(128)) bus_a();
    pipe_stage_buf_if #(.DATA_W(128)) bus_b();
    pipe_stage_buf_if #(.DATA_W(128)) bus_c();

    pipe_stage_buf #(.SKID(1'b1), .CNT_W(32)) u_a (.clk(clk), .reset(reset), .flush(flush), .bus(bus_a), .bubble_cnt(cnt_a));
    pipe_stage_buf #(.SKID(1'b0), .CNT_W(32)) u_b (.clk(clk), .reset(reset), .flush(flush), .bus(bus_b), .bubble_cnt(cnt_b));
    pipe_stage_buf #(.SKID(1'b1), .CNT_W(4))  u_c (.clk(clk), .reset(reset), .flush(flush), .bus(bus_c), .bubble_cnt(cnt_c));

    function automatic logic [127:0] dat(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'h5A5A_5A5A, pc + 32'h1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] p;
        @(negedge clk);
        if (reset || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (bus_a.out_valid && bus_a.out_ready) begin
                chk("a_sb_expected", 128'(qa.size() > 0), 128'd1);
                if (qa.size() > 0) begin
                    p = qa.pop_front();
                    chk("a_out_pc", 128'(bus_a.out_pc), 128'(p));
                    chk("a_out_data", bus_a.out_data, dat(p));
                end
            end
            if (bus_a.in_valid && bus_a.in_ready) qa.push_back(bus_a.in_pc);
            if (bus_b.out_valid && bus_b.out_ready) begin
                chk("b_sb_expected", 128'(qb.size() > 0), 128'd1);
                if (qb.size() > 0) begin
                    p = qb.pop_front();
                    chk("b_out_pc", 128'(bus_b.out_pc), 128'(p));
                    chk("b_out_data", bus_b.out_data, dat(p));
                end
            end
            if (bus_b.in_valid && bus_b.in_ready) qb.push_back(bus_b.in_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] pc, input logic rdy);
        bus_a.in_valid  = v;
        bus_a.in_pc     = pc;
        bus_a.in_data   = dat(pc);
        bus_a.out_ready = rdy;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] pc, input logic rdy);
        bus_b.in_valid  = v;
        bus_b.in_pc     = pc;
        bus_b.in_data   = dat(pc);
        bus_b.out_ready = rdy;
    endtask

    initial begin
        drive_a(1'b0, 32'h0, 1'b0);
        drive_b(1'b0, 32'h0, 1'b0);
        bus_c.in_valid  = 1'b0;
        bus_c.in_pc     = '0;
        bus_c.in_data   = '0;
        bus_c.out_ready = 1'b0;

        tick();
        tick();
        chk("a_rst_valid", 128'(bus_a.out_valid), 128'd0);
        chk("a_rst_pc", 128'(bus_a.out_pc), 128'h3000);
        chk("a_rst_data", bus_a.out_data, 128'd0);
        chk("a_rst_in_ready", 128'(bus_a.in_ready), 128'd1);
        chk("a_rst_cnt", 128'(cnt_a), 128'd0);
        chk("b_rst_valid", 128'(bus_b.out_valid), 128'd0);
        chk("b_rst_pc", 128'(bus_b.out_pc), 128'h3000);
        chk("c_rst_cnt", 128'(cnt_c), 128'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 32'h3000 + 32'(4 * i), 1'b1);
            drive_b(1'b1, 32'h3000 + 32'(4 * i), 1'b1);
            #1;
            chk("a_stream_in_ready", 128'(bus_a.in_ready), 128'd1);
            chk("b_stream_in_ready", 128'(bus_b.in_ready), 128'd1);
            tick();
            chk("a_stream_valid", 128'(bus_a.out_valid), 128'd1);
            chk("b_stream_valid", 128'(bus_b.out_valid), 128'd1);
        end
        drive_a(1'b0, 32'h0, 1'b1);
        drive_b(1'b0, 32'h0, 1'b1);
        tick();
        chk("a_drain_valid", 128'(bus_a.out_valid), 128'd0);
        chk("a_empty_pc_hold", 128'(bus_a.out_pc), 128'h301C);
        chk("a_empty_data_hold", bus_a.out_data, dat(32'h301C));
        chk("b_drain_valid", 128'(bus_b.out_valid), 128'd0);
        chk("b_empty_data_hold", bus_b.out_data, dat(32'h301C));
        drive_b(1'b0, 32'h0, 1'b0);

        drive_a(1'b1, 32'h3000, 1'b0);
        tick();
        drive_a(1'b1, 32'h3004, 1'b0);
        tick();
        chk("a_full_in_ready", 128'(bus_a.in_ready), 128'd0);
        chk("a_full_valid", 128'(bus_a.out_valid), 128'd1);
        chk("a_full_pc", 128'(bus_a.out_pc), 128'h3000);
        drive_a(1'b1, 32'h3008, 1'b0);
        tick();
        chk("a_stall_pc", 128'(bus_a.out_pc), 128'h3000);
        chk("a_stall_data", bus_a.out_data, dat(32'h3000));
        drive_a(1'b1, 32'h3008, 1'b1);
        #1;
        chk("a_release_in_ready", 128'(bus_a.in_ready), 128'd0);
        tick();
        chk("a_after_release_pc", 128'(bus_a.out_pc), 128'h3004);
        chk("a_after_release_in_ready", 128'(bus_a.in_ready), 128'd1);
        tick();
        chk("a_accept_3008_pc", 128'(bus_a.out_pc), 128'h3008);
        drive_a(1'b0, 32'h0, 1'b1);
        tick();
        chk("a_drain2_valid", 128'(bus_a.out_valid), 128'd0);

        drive_a(1'b1, 32'h3000, 1'b0);
        tick();
        drive_a(1'b1, 32'h3004, 1'b0);
        tick();
        chk("a_full2_in_ready", 128'(bus_a.in_ready), 128'd0);
        flush = 1'b1;
        drive_a(1'b1, 32'h3010, 1'b0);
        tick();
        flush = 1'b0;
        drive_a(1'b0, 32'h0, 1'b1);
        chk("a_flush_valid", 128'(bus_a.out_valid), 128'd0);
        chk("a_flush_data", bus_a.out_data, 128'd0);
        chk("a_flush_pc_hold", 128'(bus_a.out_pc), 128'h3000);
        chk("a_flush_in_ready", 128'(bus_a.in_ready), 128'd1);
        tick();
        tick();
        chk("a_post_flush_empty", 128'(bus_a.out_valid), 128'd0);
        drive_a(1'b1, 32'h3014, 1'b1);
        tick();
        drive_a(1'b0, 32'h0, 1'b1);
        tick();
        chk("a_post_flush_drain", 128'(bus_a.out_valid), 128'd0);
        drive_a(1'b0, 32'h0, 1'b0);

        drive_b(1'b1, 32'h3000, 1'b0);
        #1;
        chk("b_empty_in_ready", 128'(bus_b.in_ready), 128'd1);
        tick();
        drive_b(1'b1, 32'h3004, 1'b0);
        #1;
        chk("b_stall_in_ready", 128'(bus_b.in_ready), 128'd0);
        tick();
        chk("b_stall_pc", 128'(bus_b.out_pc), 128'h3000);
        chk("b_stall_data", bus_b.out_data, dat(32'h3000));
        drive_b(1'b1, 32'h3008, 1'b1);
        #1;
        chk("b_replace_in_ready", 128'(bus_b.in_ready), 128'd1);
        tick();
        chk("b_replace_valid", 128'(bus_b.out_valid), 128'd1);
        chk("b_replace_pc", 128'(bus_b.out_pc), 128'h3008);
        drive_b(1'b0, 32'h0, 1'b1);
        tick();
        chk("b_drain_valid2", 128'(bus_b.out_valid), 128'd0);
        chk("b_drain_data_hold", bus_b.out_data, dat(32'h3008));
        drive_b(1'b0, 32'h0, 1'b0);

        chk("a_sb_drained", 128'(qa.size()), 128'd0);
        chk("b_sb_drained", 128'(qb.size()), 128'd0);

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("c_cnt_5", 128'(cnt_c), 128'd5);
        chk("a_cnt_5", 128'(cnt_a), 128'd5);
        repeat (15) tick();
        chk("c_cnt_sat", 128'(cnt_c), 128'd15);
        chk("a_cnt_20", 128'(cnt_a), 128'd20);
        repeat (5) tick();
        chk("c_cnt_sat_hold", 128'(cnt_c), 128'd15);
        chk("a_cnt_25", 128'(cnt_a), 128'd25);
        reset = 1'b1;
        tick();
        chk("c_cnt_reset", 128'(cnt_c), 128'd0);
        chk("a_cnt_reset", 128'(cnt_a), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
